fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
- Read-side controller of the FIFO.
- Owns and advances the read pointer that feeds the empty comparator, and consumes that comparator's empty_flag to qualify reads.
- Captures the memory word at the current read pointer into a registered output and flags underflow.
- Sits between the FIFO storage array / empty comparator and the downstream consumer.

Parameters:
- SIZE, 4, pointer width in bits; FIFO depth is 2**SIZE.
- DATA_WIDTH, 8, width of each FIFO word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  consumer read request.
- empty_flag  input  1  from the empty comparator; 1 when read_pointer == write_pointer.
- mem_rdata  input  DATA_WIDTH  combinational storage-array read data at read_pointer.
- underflow_clr  input  1  clears the sticky underflow flag.
- read_pointer  output  SIZE  current read address, to the storage array and the empty comparator.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  rd_data holds a valid word.
- underflow  output  1  sticky; set by a read attempted while no data is available.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: read_pointer=0, rd_data=0, rd_valid=0, underflow=0, FSM=S_IDLE. Assertion of rst mid-operation takes effect immediately, without waiting for clk. Any in-flight read is discarded.
- Accepted read: accept = rd_en && !empty_flag.
- Default mode (macro undefined):
  - On accept, at the clk edge: rd_data <= mem_rdata; read_pointer <= read_pointer+1; rd_valid <= 1.
  - Latency is 1 cycle from the rd_en edge to rd_valid/rd_data.
  - rd_valid is a single-cycle pulse per accepted read; back-to-back accepts give a continuous rd_valid.
  - Without an accept, rd_valid <= 0 and rd_data holds its last value.
- FSM (default mode): S_IDLE, S_OUT.
  - S_IDLE -> S_OUT on accept.
  - S_OUT -> S_OUT on accept; otherwise S_OUT -> S_IDLE.
  - rd_valid is 1 exactly while in S_OUT.
- Wrap-around: read_pointer is SIZE bits and wraps 2**SIZE-1 -> 0 with no special handling. No separate wrap bit is kept; full detection is not this block's concern.
- Underflow:
  - rd_en && empty_flag sets underflow on the next edge. Pointer is unchanged and rd_valid <= 0.
  - underflow stays set until underflow_clr is sampled high.
  - Set and clear in the same cycle: set wins.
- Simultaneous write: empty_flag is used as presented in the current cycle. A word written in cycle N is readable no earlier than cycle N+1 (empty_flag deasserts then).

Optional Feature:
- Macro: FIFO_READ_FWFT_EN, first-word-fall-through mode.
- Defined:
  - FSM becomes S_EMPTY / S_HOLD; reset state is S_EMPTY.
  - In S_EMPTY with !empty_flag: prefetch rd_data <= mem_rdata, read_pointer+1, go to S_HOLD. rd_data is valid 1 cycle after data lands, with no rd_en needed.
  - In S_HOLD, rd_en means "consume current word":
    - if !empty_flag, load the next word and increment the pointer, staying in S_HOLD;
    - else go to S_EMPTY.
  - rd_valid = (state == S_HOLD).
  - Underflow is set by rd_en while in S_EMPTY; rd_en in S_HOLD never underflows.
- Undefined: default registered-read behaviour above.

Decomposition:
- Package fifo_pkg: state enum typedef, plus localparam DEPTH = 2**SIZE shared with the write side.
- One natural sub-module, fifo_ptr_cnt: SIZE-bit wrapping pointer register with async-high reset and increment enable. The write side reuses it.

Test Plan (SIZE=4, DATA_WIDTH=8):
- Reset: assert rst mid-stream with read_pointer=5 -> read_pointer=0, rd_valid=0, underflow=0 immediately, before the next clk edge.
- Single read: empty_flag=0, mem_rdata=8'hA5, rd_en pulse 1 cycle -> next cycle rd_data=8'hA5, rd_valid=1 for exactly 1 cycle, read_pointer 0->1.
- Burst and wrap: start read_pointer=14, 4 back-to-back accepts -> pointer 15, 0, 1, 2; rd_valid high 4 consecutive cycles.
- Underflow: empty_flag=1, rd_en=1 -> pointer unchanged, rd_valid=0, underflow=1 and held. Then underflow_clr=1 together with a new underflow attempt -> underflow stays 1. underflow_clr alone -> underflow=0.
- FWFT (macro on): empty_flag falls with mem_rdata=8'h3C, rd_en=0 -> next cycle rd_data=8'h3C, rd_valid=1, pointer+1. Then rd_en=1 with empty_flag=1 -> rd_valid=0, underflow=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-side state encoding and depth constants.
// Read-side state set depends on FIFO_READ_FWFT_EN (first-word-fall-through).
package fifo_pkg;

  localparam int FIFO_SIZE       = 4;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int DEPTH           = 2 ** FIFO_SIZE;

`ifdef FIFO_READ_FWFT_EN
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } rd_state_t;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } rd_state_t;
`endif

endpackage

// File: rtl/fifo_ptr_cnt.sv
// SIZE-bit wrapping pointer register, shared by the read and write sides.
// Advances by one on the clock edge when inc is high; wraps 2**SIZE-1 -> 0.
module fifo_ptr_cnt #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [SIZE-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + SIZE'(1);
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: registered read (1-cycle latency) or, with FIFO_READ_FWFT_EN, first-word-fall-through.
// No backpressure beyond empty_flag; a read while nothing is available sets the sticky underflow flag.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE       = FIFO_SIZE,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  empty_flag,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  underflow_clr,
  output logic [SIZE-1:0]       read_pointer,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  underflow
);

  rd_state_t state;
  rd_state_t state_nxt;
  logic      load;
  logic      uf_set;

  fifo_ptr_cnt #(
    .SIZE(SIZE)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .inc(load),
    .ptr(read_pointer)
  );

`ifdef FIFO_READ_FWFT_EN
  // Prefetch whenever empty so the head word is presented without a request.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    uf_set    = 1'b0;
    case (state)
      S_EMPTY: begin
        uf_set = rd_en;
        if (!empty_flag) begin
          load      = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rd_en) begin
          if (!empty_flag) begin
            load = 1'b1;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  assign rd_valid = (state == S_HOLD);
`else
  logic accept;

  assign accept = rd_en && !empty_flag;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    uf_set    = rd_en && empty_flag;
    case (state)
      S_IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (accept) begin
          load = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_valid = (state == S_OUT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= rd_state_t'(1'b0);
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= mem_rdata;
    end
  end

  // A new underflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (uf_set) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl in registered-read mode: reference model plus directed literal checks.
module tb_fifo_read_ctrl;
  import fifo_pkg::*;

  localparam int SIZE = 4;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            rd_en;
  logic            empty_flag;
  logic            underflow_clr;
  logic [DW-1:0]   mem_rdata;
  logic [SIZE-1:0] read_pointer;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            underflow;

  logic [DW-1:0] mem [DEPTH];
  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  // Reference model: pointer is the count of accepted reads modulo depth.
  int          m_reads;
  logic [DW-1:0] m_data;
  logic        m_valid;
  logic        m_uf;

  logic [SIZE-1:0] exp_p [4];
  logic [DW-1:0]   exp_d [4];

  always #5 clk = ~clk;

  assign mem_rdata = mem[read_pointer];

  fifo_read_ctrl #(
    .SIZE(SIZE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .empty_flag(empty_flag),
    .mem_rdata(mem_rdata),
    .underflow_clr(underflow_clr),
    .read_pointer(read_pointer),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reads <= 0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_uf    <= 1'b0;
    end else begin
      m_valid <= rd_en && !empty_flag;
      if (rd_en && !empty_flag) begin
        m_data  <= mem[m_reads % DEPTH];
        m_reads <= m_reads + 1;
      end
      if (rd_en && empty_flag) m_uf <= 1'b1;
      else if (underflow_clr)  m_uf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      check("cmp_ptr",   32'(read_pointer), 32'(m_reads % DEPTH));
      check("cmp_valid", 32'(rd_valid),     32'(m_valid));
      check("cmp_data",  32'(rd_data),      32'(m_data));
      check("cmp_uf",    32'(underflow),    32'(m_uf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rd_en = 1'b0;
    empty_flag = 1'b1;
    underflow_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    mem[0] = 8'hA5;
    exp_p = '{4'd15, 4'd0, 4'd1, 4'd2};
    exp_d = '{8'h1E, 8'h1F, 8'hA5, 8'h11};

    #1 rst = 1'b1;
    #1;
    check("rst_ptr",   32'(read_pointer), 32'd0);
    check("rst_valid", 32'(rd_valid),     32'd0);
    check("rst_data",  32'(rd_data),      32'd0);
    check("rst_uf",    32'(underflow),    32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk_on = 1'b1;

    // Single read of the word at address 0.
    empty_flag = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("single_data",  32'(rd_data),      32'hA5);
    check("single_valid", 32'(rd_valid),     32'd1);
    check("single_ptr",   32'(read_pointer), 32'd1);
    tick();
    check("single_pulse", 32'(rd_valid), 32'd0);
    check("single_hold",  32'(rd_data),  32'hA5);

    // Underflow left set across the mid-stream reset.
    empty_flag = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("uf1_set", 32'(underflow),    32'd1);
    check("uf1_ptr", 32'(read_pointer), 32'd1);

    empty_flag = 1'b0;
    rd_en = 1'b1;
    repeat (4) tick();
    check("stream_ptr",   32'(read_pointer), 32'd5);
    check("stream_valid", 32'(rd_valid),     32'd1);
    check("stream_uf",    32'(underflow),    32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ptr",   32'(read_pointer), 32'd0);
    check("arst_valid", 32'(rd_valid),     32'd0);
    check("arst_uf",    32'(underflow),    32'd0);
    check("arst_data",  32'(rd_data),      32'd0);
    rd_en = 1'b0;
    tick();
    rst = 1'b0;

    // Advance to pointer 14, then burst across the wrap.
    rd_en = 1'b1;
    repeat (14) tick();
    check("pre_ptr", 32'(read_pointer), 32'd14);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_ptr",   32'(read_pointer), 32'(exp_p[k]));
      check("burst_valid", 32'(rd_valid),     32'd1);
      check("burst_data",  32'(rd_data),      32'(exp_d[k]));
    end
    rd_en = 1'b0;
    tick();
    check("burst_end_valid", 32'(rd_valid), 32'd0);
    check("burst_end_hold",  32'(rd_data),  32'h11);

    // Sticky underflow, set-over-clear priority, then clear.
    empty_flag = 1'b1;
    rd_en = 1'b1;
    tick();
    check("uf2_set",   32'(underflow),    32'd1);
    check("uf2_ptr",   32'(read_pointer), 32'd2);
    check("uf2_valid", 32'(rd_valid),     32'd0);
    rd_en = 1'b0;
    tick();
    check("uf2_held", 32'(underflow), 32'd1);
    rd_en = 1'b1;
    underflow_clr = 1'b1;
    tick();
    check("uf2_set_wins", 32'(underflow), 32'd1);
    rd_en = 1'b0;
    tick();
    check("uf2_cleared", 32'(underflow), 32'd0);
    underflow_clr = 1'b0;

    // Data becomes available: empty_flag drops with a read pending.
    empty_flag = 1'b0;
    rd_en = 1'b1;
    tick();
    check("avail_data", 32'(rd_data),      32'h12);
    check("avail_ptr",  32'(read_pointer), 32'd3);
    rd_en = 1'b0;
    tick();
    tick();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
